// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: column-scan controller for a 5-column x 7-row LED matrix.
// Steps a 3-bit column select and drives the matching active-low row pattern
// from a double-buffered frame store. The host writes the back buffer and
// requests a swap, which is applied only on the column 4 -> 0 wrap.
//
// Optional feature macro: SCAN_BLANK_EN
//   defined   - row_n is dark for the first BLANK_CYC cycles of every dwell
//   undefined - row data is shown for the whole dwell; BLANK_CYC is unused
//
// Host strobes: wr_en and swap_req are one-way strobes with no ready/backpressure.
// A write is taken in any cycle where wr_en=1 and wr_col<=4. A swap request is
// always accepted and held in swap_pending until the next wrap executes it;
// repeated requests before that wrap collapse into one swap.
module matrix_scan_ctrl #(
  parameter int DIV       = 1000,
  parameter int BLANK_CYC = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [6:0] wr_data,
  input  logic       swap_req,
  output logic [2:0] col_sel,
  output logic [6:0] row_n,
  output logic       frame_tick,
  output logic       swap_pending
);

  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  logic [PW-1:0] pcnt;
  logic [PW-1:0] pcnt_nxt;
  logic [2:0]    col_nxt;
  logic [6:0]    front [5];
  logic [6:0]    back  [5];
  logic          last_cyc;
  logic          wrap;
  logic          do_swap;
  logic          blank_nxt;
  logic [6:0]    row_data_nxt;

  // Last cycle of a dwell, the frame wrap, and whether the wrap copies buffers.
  assign last_cyc = enable && (pcnt == PCNT_LAST);
  assign wrap     = last_cyc && (col_sel == 3'd4);
  assign do_swap  = wrap && (swap_pending || swap_req);

  // Prescaler next value: counts while enabled, cleared while frozen.
  always_comb begin
    pcnt_nxt = '0;
    if (enable && !last_cyc) pcnt_nxt = pcnt + 1'b1;
  end

  // Column pointer next value: steps 0..4 and wraps, holds otherwise.
  always_comb begin
    col_nxt = col_sel;
    if (last_cyc) col_nxt = (col_sel == 3'd4) ? 3'd0 : col_sel + 3'd1;
  end

  // Row data for the column that will be shown after this edge; a swap on the
  // same edge means the freshly copied back-buffer row is the one displayed.
  always_comb begin
    row_data_nxt = '0;
    for (int i = 0; i < 5; i++) begin
      if (col_nxt == 3'(i)) row_data_nxt = do_swap ? back[i] : front[i];
    end
  end

`ifdef SCAN_BLANK_EN
  localparam logic [PW-1:0] BLANK_LEN = PW'(BLANK_CYC);
  assign blank_nxt = !enable || (pcnt_nxt < BLANK_LEN);
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = (BLANK_CYC < DIV);
  assign blank_nxt = !enable;
`endif

  // Scan state: prescaler, column select, row drive and frame pulse move together
  // so row_n always belongs to col_sel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      col_sel    <= 3'd0;
      row_n      <= 7'h7F;
      frame_tick <= 1'b0;
    end else begin
      pcnt       <= pcnt_nxt;
      col_sel    <= col_nxt;
      row_n      <= blank_nxt ? 7'h7F : ~row_data_nxt;
      frame_tick <= wrap;
    end
  end

  // Swap request latch: set by a request, cleared by the wrap that serves it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swap_pending <= 1'b0;
    end else if (do_swap) begin
      swap_pending <= 1'b0;
    end else if (swap_req) begin
      swap_pending <= 1'b1;
    end
  end

  // Front buffer: whole-image copy from the back buffer at a served wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) front[i] <= '0;
    end else if (do_swap) begin
      for (int i = 0; i < 5; i++) front[i] <= back[i];
    end
  end

  // Back buffer: host writes; column addresses 5..7 match no entry and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) back[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (wr_en && (wr_col == 3'(i))) back[i] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Testbench for matrix_scan_ctrl with DIV=4, BLANK_CYC=1. A behavioural model
// of the display (frame store, dwell position, pending swap) is advanced on
// every rising edge and compared with the DUT outputs 1 ns later.
module tb_matrix_scan_ctrl;

  localparam int DIV       = 4;
  localparam int BLANK_CYC = 1;
`ifdef SCAN_BLANK_EN
  localparam int M_BLANK = BLANK_CYC;
`else
  localparam int M_BLANK = 0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       enable   = 1'b0;
  logic       wr_en    = 1'b0;
  logic [2:0] wr_col   = 3'd0;
  logic [6:0] wr_data  = 7'd0;
  logic       swap_req = 1'b0;
  logic [2:0] col_sel;
  logic [6:0] row_n;
  logic       frame_tick;
  logic       swap_pending;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_pcnt;
  int         m_col;
  logic [6:0] m_front [5];
  logic [6:0] m_back  [5];
  logic       m_pend;
  logic       m_tick;
  logic [6:0] m_row;
  logic [6:0] exp_q [$];

  matrix_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .col_sel      (col_sel),
    .row_n        (row_n),
    .frame_tick   (frame_tick),
    .swap_pending (swap_pending)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pcnt = 0;
    m_col  = 0;
    m_pend = 1'b0;
    m_tick = 1'b0;
    m_row  = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      m_front[i] = 7'd0;
      m_back[i]  = 7'd0;
    end
  endtask

  // Driver: one clock edge, model follows the display rules, outputs settle.
  task automatic step();
    logic wrap;
    logic swp;
    @(posedge clk);
    wrap = enable && (m_pcnt == DIV - 1) && (m_col == 4);
    swp  = wrap && (m_pend || swap_req);
    if (swp) for (int i = 0; i < 5; i++) m_front[i] = m_back[i];
    if (wr_en && wr_col <= 3'd4) m_back[wr_col] = wr_data;
    m_pend = swp ? 1'b0 : (m_pend || swap_req);
    m_tick = wrap;
    if (!enable) begin
      m_pcnt = 0;
    end else if (m_pcnt == DIV - 1) begin
      m_pcnt = 0;
      m_col  = (m_col + 1) % 5;
    end else begin
      m_pcnt = m_pcnt + 1;
    end
    m_row = (!enable || m_pcnt < M_BLANK) ? 7'h7F : ~m_front[m_col];
    #1;
  endtask

  task automatic write_back(input logic [2:0] c, input logic [6:0] d);
    wr_en = 1'b1; wr_col = c; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
  endtask

  // Step until the model sits at (col, pcnt); ok=0 if the budget runs out.
  task automatic run_until(input int col, input int pc, input int bound, output bit ok);
    int n;
    n = 0;
    while (!(m_col == col && m_pcnt == pc) && n < bound) begin
      step();
      n++;
    end
    ok = (m_col == col && m_pcnt == pc);
  endtask

  task automatic test_reset();
    enable = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    model_reset();
    checks++;
    if (col_sel !== 3'd0) begin errors++; $display("FAIL reset_col got %0d exp 0", col_sel); end
    checks++;
    if (row_n !== 7'h7F) begin errors++; $display("FAIL reset_row got %h exp 7f", row_n); end
    checks++;
    if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    checks++;
    if (swap_pending !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", swap_pending); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    int ticks;
    ticks = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (frame_tick === 1'b1) ticks++;
      checks++;
      if (col_sel !== 3'((k / DIV) % 5)) begin
        errors++; $display("FAIL idle_col k=%0d got %0d exp %0d", k, col_sel, (k / DIV) % 5);
      end
      checks++;
      if ({col_sel, row_n, frame_tick, swap_pending} !== {3'(m_col), m_row, m_tick, m_pend}) begin
        errors++; $display("FAIL idle_snap k=%0d got %h exp %h", k,
          {col_sel, row_n, frame_tick, swap_pending}, {3'(m_col), m_row, m_tick, m_pend});
      end
    end
    checks++;
    if (ticks != 25 / (5 * DIV)) begin errors++; $display("FAIL idle_ticks got %0d exp %0d", ticks, 25 / (5 * DIV)); end
  endtask

  task automatic test_write_swap();
    bit ok;
    int n;
    logic [6:0] e;
    write_back(3'd2, 7'h55);
    run_until(1, 0, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ws_reach_col1 got col %0d exp 1", m_col); end
    pulse_swap();
    checks++;
    if (swap_pending !== 1'b1) begin errors++; $display("FAIL ws_pend_rise got %b exp 1", swap_pending); end
    n = 0;
    while (!m_tick && n < 100) begin
      step();
      n++;
      if (!m_tick) begin
        checks++;
        if ({row_n, swap_pending} !== {7'h7F, 1'b1}) begin
          errors++; $display("FAIL ws_before_wrap got row=%h pend=%b exp row=7f pend=1", row_n, swap_pending);
        end
      end
    end
    checks++;
    if ({frame_tick, swap_pending} !== 2'b10) begin
      errors++; $display("FAIL ws_wrap got tick=%b pend=%b exp tick=1 pend=0", frame_tick, swap_pending);
    end
`ifdef SCAN_BLANK_EN
    exp_q.push_back(7'h7F);
`else
    exp_q.push_back(7'h2A);
`endif
    exp_q.push_back(7'h2A);
    exp_q.push_back(7'h2A);
    exp_q.push_back(7'h2A);
    run_until(2, 0, 100, ok);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      e = exp_q.pop_front();
      checks++;
      if ({col_sel, row_n} !== {3'd2, e}) begin
        errors++; $display("FAIL ws_col2_row j=%0d got col=%0d row=%h exp col=2 row=%h", j, col_sel, row_n, e);
      end
    end
  endtask

  task automatic test_swap_on_wrap();
    bit ok;
    bit rose;
    logic [6:0] v;
    v = 7'($urandom_range(1, 127));
    write_back(3'd4, v);
    run_until(4, DIV - 1, 100, ok);
    checks++;
    if (swap_pending !== 1'b0) begin errors++; $display("FAIL sow_pre_pend got %b exp 0", swap_pending); end
    pulse_swap();
    checks++;
    if ({frame_tick, swap_pending} !== 2'b10) begin
      errors++; $display("FAIL sow_wrap got tick=%b pend=%b exp tick=1 pend=0", frame_tick, swap_pending);
    end
    rose = 1'b0;
    while (!(m_col == 4 && m_pcnt == DIV - 1)) begin
      step();
      if (swap_pending !== 1'b0) rose = 1'b1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL sow_pend_rose got 1 exp 0"); end
    checks++;
    if (row_n !== ~v) begin errors++; $display("FAIL sow_row got %h exp %h", row_n, ~v); end
  endtask

  task automatic test_write_during_swap();
    bit ok;
    logic [6:0] a;
    a = 7'($urandom_range(1, 126));
    write_back(3'd0, a);
    pulse_swap();
    run_until(4, DIV - 1, 100, ok);
    wr_en = 1'b1; wr_col = 3'd0; wr_data = 7'h7F;
    step();
    wr_en = 1'b0;
    run_until(0, DIV - 1, 100, ok);
    checks++;
    if (row_n !== ~a) begin errors++; $display("FAIL wds_old_row got %h exp %h", row_n, ~a); end
    pulse_swap();
    run_until(0, DIV - 1, 100, ok);
    checks++;
    if (row_n !== 7'h00) begin errors++; $display("FAIL wds_new_row got %h exp 00", row_n); end
  endtask

  task automatic test_enable_freeze();
    bit ok;
    logic [6:0] v;
    v = 7'($urandom_range(1, 127));
    write_back(3'd3, v);
    pulse_swap();
    run_until(4, DIV - 1, 100, ok);
    step();
    run_until(3, 1, 100, ok);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({col_sel, row_n, frame_tick} !== {3'd3, 7'h7F, 1'b0}) begin
        errors++; $display("FAIL frz_hold k=%0d got col=%0d row=%h tick=%b exp col=3 row=7f tick=0",
          k, col_sel, row_n, frame_tick);
      end
    end
    enable = 1'b1;
    for (int k = 1; k <= DIV; k++) begin
      step();
      checks++;
      if (k < DIV) begin
        if ({col_sel, row_n} !== {3'd3, ~v}) begin
          errors++; $display("FAIL frz_resume k=%0d got col=%0d row=%h exp col=3 row=%h", k, col_sel, row_n, ~v);
        end
      end else if (col_sel !== 3'd4) begin
        errors++; $display("FAIL frz_advance got col=%0d exp 4", col_sel);
      end
    end
  endtask

  task automatic test_ignored_addr();
    bit ok;
    logic [6:0] known [5];
    for (int i = 0; i < 5; i++) begin
      known[i] = 7'($urandom_range(0, 127));
      write_back(3'(i), known[i]);
    end
    pulse_swap();
    run_until(4, DIV - 1, 100, ok);
    step();
    for (int k = 0; k < 6; k++) write_back(3'($urandom_range(5, 7)), 7'($urandom));
    pulse_swap();
    run_until(4, DIV - 1, 100, ok);
    step();
    for (int c = 0; c < 5; c++) begin
      run_until(c, DIV - 1, 100, ok);
      checks++;
      if ({col_sel, row_n} !== {3'(c), ~known[c]}) begin
        errors++; $display("FAIL ign_row c=%0d got col=%0d row=%h exp row=%h", c, col_sel, row_n, ~known[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      enable   = ($urandom_range(0, 9) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_col   = 3'($urandom_range(0, 7));
      wr_data  = 7'($urandom);
      swap_req = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if ({col_sel, row_n, frame_tick, swap_pending} !== {3'(m_col), m_row, m_tick, m_pend}) begin
        errors++; $display("FAIL rand_snap k=%0d got %h exp %h", k,
          {col_sel, row_n, frame_tick, swap_pending}, {3'(m_col), m_row, m_tick, m_pend});
      end
    end
    enable = 1'b1; wr_en = 1'b0; swap_req = 1'b0;
    step();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    run_until(1, 1, 100, ok);
    write_back(3'd1, 7'h33);
    pulse_swap();
    checks++;
    if (swap_pending !== 1'b1) begin errors++; $display("FAIL rmf_pend_set got %b exp 1", swap_pending); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({col_sel, row_n, frame_tick, swap_pending} !== {3'd0, 7'h7F, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rmf_async got %h exp %h", {col_sel, row_n, frame_tick, swap_pending},
        {3'd0, 7'h7F, 1'b0, 1'b0});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      if (k == 2) pulse_swap(); else step();
      checks++;
      if ({col_sel, row_n, frame_tick, swap_pending} !== {3'(m_col), m_row, m_tick, m_pend}) begin
        errors++; $display("FAIL rmf_snap k=%0d got %h exp %h", k,
          {col_sel, row_n, frame_tick, swap_pending}, {3'(m_col), m_row, m_tick, m_pend});
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_write_swap();
    test_swap_on_wrap();
    test_write_during_swap();
    test_enable_freeze();
    test_ignored_addr();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
